// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl
// Two-port (core / debug) arbiter and read-modify-write sequencer in front of
// a synchronous-read CSR file. Each accepted request runs IDLE -> RD -> WB:
// RD presents the address to the CSR file, WB computes and writes the new value
// and returns the old one to the requesting port. Addresses whose top two bits
// are 2'b11 are read-only; a write attempt there is suppressed and flagged.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   core_req_* / dbg_req_*      request handshake + payload (op, wr_en, addr, wdata)
//   core_resp_* / dbg_resp_*    one-cycle response pulse, old value, illegal flag
//   csr_rd_addr / csr_rd_val    CSR file read port (one-cycle latency)
//   csr_write / csr_wr_addr / csr_wr_val   CSR file write port
//   busy                        sequencer not idle
module csr_access_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              core_req_valid,
    output logic              core_req_ready,
    input  logic [1:0]        core_op,
    input  logic              core_wr_en,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_resp_valid,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_illegal,

    input  logic              dbg_req_valid,
    output logic              dbg_req_ready,
    input  logic [1:0]        dbg_op,
    input  logic              dbg_wr_en,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_resp_valid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_illegal,

    output logic [ADDR_W-1:0] csr_rd_addr,
    input  logic [DATA_W-1:0] csr_rd_val,
    output logic              csr_write,
    output logic [ADDR_W-1:0] csr_wr_addr,
    output logic [DATA_W-1:0] csr_wr_val,

    output logic              busy
);

    typedef enum logic [1:0] {IDLE, RD, WB} state_t;

    state_t            state;
    logic              prio_dbg;   // 1: debug port favoured on contention
    logic              src_dbg;    // owner of the in-flight access
    logic [1:0]        op_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] core_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;

    logic              idle;
    logic              in_wb;
    logic              core_go;
    logic              dbg_go;
    logic              do_wr;
    logic              ro;
    logic [DATA_W-1:0] new_val;

    assign idle  = (state == IDLE);
    assign in_wb = (state == WB);
    assign busy  = !idle;

    // Favoured requester wins; the other only gets in when the favoured one is quiet.
    assign core_req_ready = idle && (!prio_dbg || !dbg_req_valid);
    assign dbg_req_ready  = idle && ( prio_dbg || !core_req_valid);
    assign core_go = core_req_valid && core_req_ready;
    assign dbg_go  = dbg_req_valid && dbg_req_ready;

    assign do_wr = (op_q == 2'b01) || (op_q[1] && wr_en_q);
    assign ro    = (addr_q[ADDR_W-1 -: 2] == 2'b11);

    always_comb begin
        new_val = wdata_q;
        case (op_q)
            2'b10:   new_val = csr_rd_val | wdata_q;
            2'b11:   new_val = csr_rd_val & ~wdata_q;
            default: new_val = wdata_q;
        endcase
    end

    // The old value only appears on csr_rd_val during WB, so the write port and
    // the response are decoded from state rather than registered a cycle late.
    assign csr_rd_addr = addr_q;
    assign csr_write   = in_wb && do_wr && !ro;
    assign csr_wr_addr = in_wb ? addr_q  : '0;
    assign csr_wr_val  = in_wb ? new_val : '0;

    assign core_resp_valid = in_wb && !src_dbg;
    assign dbg_resp_valid  = in_wb &&  src_dbg;
    assign core_illegal    = core_resp_valid && do_wr && ro;
    assign dbg_illegal     = dbg_resp_valid  && do_wr && ro;
    // Old value passes straight through on the pulse, then is held.
    assign core_rdata = core_resp_valid ? csr_rd_val : core_rdata_q;
    assign dbg_rdata  = dbg_resp_valid  ? csr_rd_val : dbg_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            prio_dbg     <= 1'b0;
            src_dbg      <= 1'b0;
            op_q         <= 2'b00;
            wr_en_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (core_go) begin
                        op_q     <= core_op;
                        wr_en_q  <= core_wr_en;
                        addr_q   <= core_addr;
                        wdata_q  <= core_wdata;
                        src_dbg  <= 1'b0;
                        prio_dbg <= 1'b1;
                        state    <= RD;
                    end else if (dbg_go) begin
                        op_q     <= dbg_op;
                        wr_en_q  <= dbg_wr_en;
                        addr_q   <= dbg_addr;
                        wdata_q  <= dbg_wdata;
                        src_dbg  <= 1'b1;
                        prio_dbg <= 1'b0;
                        state    <= RD;
                    end
                end
                RD: state <= WB;
                WB: begin
                    if (src_dbg) dbg_rdata_q  <= csr_rd_val;
                    else         core_rdata_q <= csr_rd_val;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
